// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: shared funct3 codes, FSM states, IALIGN values and decision helpers
package branch_resolve_ctrl_pkg;
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;
    localparam int IALIGN_16 = 16;
    localparam int IALIGN_32 = 32;
    typedef enum logic [1:0] {IDLE, CMP, RES, REDIR} br_state_e;
    // 010/011 are the only unused branch encodings
    function automatic logic br_illegal(input logic [2:0] f);
        return f[2:1] == 2'b01;
    endfunction
    // bit 2 picks lt vs eq, bit 0 inverts the condition
    function automatic logic br_taken(input logic [2:0] f, input logic eq, input logic lt);
        return f[2] ? (lt ^ f[0]) : (eq ^ f[0]);
    endfunction
endpackage

// File: rtl/branch_cmp_core.sv
// branch_cmp_core: combinational XLEN comparator with signed/unsigned select
module branch_cmp_core #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            unsigned_i,
    output logic            eq_o,
    output logic            lt_o
);
    assign eq_o = a_i == b_i;
    assign lt_o = unsigned_i ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: execute-stage branch resolve FSM; BRANCH_STATS_EN adds saturating stat counters
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = IALIGN_32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    input  logic            flush_in,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            done_valid,
    output logic            done_taken,
    output logic            done_exc,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_exc,
`endif
    output logic            busy
);
    br_state_e       state_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q, redir_pc_q;
    logic            redir_valid_q, done_q, taken_q, exc_q;
    logic            eq, lt, cond, misal, hs;
    logic [XLEN-1:0] target;

    branch_cmp_core #(.XLEN(XLEN)) u_cmp (
        .a_i        (rs1_q),
        .b_i        (rs2_q),
        .unsigned_i (funct3_q[2:1] == BR_BLTU[2:1]),
        .eq_o       (eq),
        .lt_o       (lt)
    );

    assign target = pc_q + imm_q;
    assign misal  = (IALIGN == IALIGN_16) ? target[0] : |target[1:0];
    assign cond   = br_taken(funct3_q, eq, lt);
    assign hs     = redir_valid_q & redir_ready & ~flush_in;

    // The redirect-accept pulse must appear in the handshake cycle itself, so it is
    // folded in from redir_ready; a same-cycle flush suppresses any report.
    assign req_ready   = (state_q == IDLE) & ~flush_in;
    assign busy        = state_q != IDLE;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign done_valid  = ~flush_in & (done_q | hs);
    assign done_taken  = ~flush_in & ((done_q & taken_q) | hs);
    assign done_exc    = ~flush_in & done_q & exc_q;

    // Resolve FSM: decision is made on the CMP->RES edge so results are registered in RES
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            funct3_q      <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            pc_q          <= '0;
            imm_q         <= '0;
            redir_pc_q    <= '0;
            redir_valid_q <= 1'b0;
            done_q        <= 1'b0;
            taken_q       <= 1'b0;
            exc_q         <= 1'b0;
        end else if (flush_in) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            done_q        <= 1'b0;
            taken_q       <= 1'b0;
            exc_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    funct3_q <= req_funct3;
                    rs1_q    <= req_rs1;
                    rs2_q    <= req_rs2;
                    pc_q     <= req_pc;
                    imm_q    <= req_imm;
                    state_q  <= CMP;
                end
                CMP: begin
                    state_q <= RES;
                    if (br_illegal(funct3_q)) begin
                        done_q <= 1'b1;
                        exc_q  <= 1'b1;
                    end else if (cond && misal) begin
                        done_q  <= 1'b1;
                        exc_q   <= 1'b1;
                        taken_q <= 1'b1;
                    end else if (!cond) begin
                        done_q <= 1'b1;
                    end else begin
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= target;
                    end
                end
                RES, REDIR: begin
                    done_q  <= 1'b0;
                    taken_q <= 1'b0;
                    exc_q   <= 1'b0;
                    if (!redir_valid_q) state_q <= IDLE;
                    else if (redir_ready) begin
                        redir_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end else state_q <= REDIR;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] res_q, tk_q, ex_q;
    assign stat_resolved = res_q;
    assign stat_taken    = tk_q;
    assign stat_exc      = ex_q;
    // Saturating counts of reported resolutions; flushed branches never raise done_valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_q <= '0;
            tk_q  <= '0;
            ex_q  <= '0;
        end else begin
            if (done_valid && ~&res_q) res_q <= res_q + 32'd1;
            if (done_taken && ~&tk_q) tk_q <= tk_q + 32'd1;
            if (done_exc && ~&ex_q) ex_q <= ex_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: table vectors, corner sequences and randomized model check
module tb_branch_resolve_ctrl;
    logic clock = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, v16 = 1'b0, flush_in = 1'b0, redir_ready = 1'b0, rr16 = 1'b0;
    logic [2:0] req_funct3 = '0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0, req_pc = '0, req_imm = '0;
    logic req_ready, redir_valid, done_valid, done_taken, done_exc, busy;
    logic [31:0] redir_pc;
    logic req_ready16, redir_valid16, done_valid16, done_taken16, done_exc16, busy16;
    logic [31:0] redir_pc16;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved, stat_taken, stat_exc, sr16, st16, se16;
`endif
    int vectors = 0, miscompares = 0;
    logic [31:0] n_res = '0, n_tk = '0, n_ex = '0;

    always #5 clock = ~clock;

    branch_resolve_ctrl #(.XLEN(32), .IALIGN(32)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc),
        .req_imm(req_imm), .flush_in(flush_in), .redir_valid(redir_valid),
        .redir_ready(redir_ready), .redir_pc(redir_pc), .done_valid(done_valid),
        .done_taken(done_taken), .done_exc(done_exc),
`ifdef BRANCH_STATS_EN
        .stat_resolved(stat_resolved), .stat_taken(stat_taken), .stat_exc(stat_exc),
`endif
        .busy(busy));

    branch_resolve_ctrl #(.XLEN(32), .IALIGN(16)) dut16 (
        .clock(clock), .reset(reset), .req_valid(v16), .req_ready(req_ready16),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc),
        .req_imm(req_imm), .flush_in(flush_in), .redir_valid(redir_valid16),
        .redir_ready(rr16), .redir_pc(redir_pc16), .done_valid(done_valid16),
        .done_taken(done_taken16), .done_exc(done_exc16),
`ifdef BRANCH_STATS_EN
        .stat_resolved(sr16), .stat_taken(st16), .stat_exc(se16),
`endif
        .busy(busy16));

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, pc, imm;
        int          w;
        logic        tk, ex, rd;
        logic [31:0] tgt;
    } vec_t;
    vec_t tbl [12];

    task automatic chk_b(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reference: branch semantics straight from the ISA rules
    task automatic model(input logic [2:0] f, input logic [31:0] a, b, pc, imm,
                         output logic tk, ex, rd, output logic [31:0] tgt);
        int sa, sb;
        logic c;
        logic ill;
        sa = a;
        sb = b;
        ill = 1'b0;
        c = 1'b0;
        case (f)
            3'b000: c = a == b;
            3'b001: c = a != b;
            3'b100: c = sa < sb;
            3'b101: c = sa >= sb;
            3'b110: c = a < b;
            3'b111: c = a >= b;
            default: ill = 1'b1;
        endcase
        tgt = pc + imm;
        tk = !ill && c;
        ex = ill || (c && (tgt % 4 != 0));
        rd = tk && !ex;
        if (!rd) tgt = '0;
    endtask

    task automatic run_br(input logic [2:0] f, input logic [31:0] a, b, pc, imm, input int w,
                          input logic etk, eex, erd, input logic [31:0] epc);
        cyc();
        req_valid = 1'b1; req_funct3 = f; req_rs1 = a; req_rs2 = b; req_pc = pc; req_imm = imm;
        @(negedge clock);
        chk_b("req_ready_idle", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0; req_funct3 = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
        req_pc = $urandom; req_imm = $urandom;
        @(negedge clock);
        chk_b("busy_cmp", busy, 1'b1);
        chk_b("done_early", done_valid, 1'b0);
        chk_b("redir_early", redir_valid, 1'b0);
        n_res = n_res + 32'd1;
        if (etk) n_tk = n_tk + 32'd1;
        if (eex) n_ex = n_ex + 32'd1;
        if (erd) begin
            for (int i = 0; i <= w; i++) begin
                cyc();
                redir_ready = (i == w);
                @(negedge clock);
                chk_b("redir_valid", redir_valid, 1'b1);
                chk_w("redir_pc", redir_pc, epc);
                chk_b("done_valid_redir", done_valid, i == w);
                chk_b("done_taken_redir", done_taken, i == w);
                chk_b("done_exc_redir", done_exc, 1'b0);
            end
        end else begin
            cyc();
            @(negedge clock);
            chk_b("done_valid", done_valid, 1'b1);
            chk_b("done_taken", done_taken, etk);
            chk_b("done_exc", done_exc, eex);
            chk_b("no_redir", redir_valid, 1'b0);
        end
        cyc();
        redir_ready = 1'b0;
        @(negedge clock);
        chk_b("done_after", done_valid, 1'b0);
        chk_b("redir_after", redir_valid, 1'b0);
        chk_b("busy_after", busy, 1'b0);
        chk_b("ready_after", req_ready, 1'b1);
    endtask

    // Accept a taken BEQ 0x100+0x20 and advance to the first redirect cycle
    task automatic to_redir();
        cyc();
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h5; req_rs2 = 32'h5;
        req_pc = 32'h100; req_imm = 32'h20;
        @(negedge clock);
        cyc();
        req_valid = 1'b0;
        @(negedge clock);
        cyc();
        @(negedge clock);
        chk_b("to_redir_valid", redir_valid, 1'b1);
        chk_w("to_redir_pc", redir_pc, 32'h120);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tk, ex, rd;
        logic [31:0] tgt, a, b, pc, imm;
        logic [2:0] f;
        tbl[0]  = '{3'b000, 32'h5,        32'h5,        32'h100,      32'h20,       3, 1'b1, 1'b0, 1'b1, 32'h120};
        tbl[1]  = '{3'b100, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       0, 1'b1, 1'b0, 1'b1, 32'h240};
        tbl[2]  = '{3'b110, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{3'b001, 32'h1,        32'h2,        32'h100,      32'h6,        0, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{3'b010, 32'h5,        32'h5,        32'h300,      32'h8,        0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{3'b101, 32'h3,        32'h3,        32'hFFFFFFF0, 32'h20,       1, 1'b1, 1'b0, 1'b1, 32'h10};
        tbl[6]  = '{3'b111, 32'h1,        32'hFFFFFFFF, 32'h400,      32'h10,       0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{3'b011, 32'h7,        32'h7,        32'h400,      32'h10,       0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{3'b001, 32'h7,        32'h7,        32'h400,      32'h10,       0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{3'b000, 32'h9,        32'h9,        32'h100,      32'h2,        0, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{3'b101, 32'hFFFFFFFE, 32'h1,        32'h100,      32'h8,        0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{3'b111, 32'hFFFFFFFE, 32'h1,        32'h1000,     32'hFFFFFFF0, 2, 1'b1, 1'b0, 1'b1, 32'hFF0};

        #1;
        chk_b("rst_req_ready", req_ready, 1'b1);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_redir_valid", redir_valid, 1'b0);
        chk_w("rst_redir_pc", redir_pc, 32'h0);
        chk_b("rst_done_valid", done_valid, 1'b0);
        cyc();
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++)
            run_br(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].pc, tbl[i].imm, tbl[i].w,
                   tbl[i].tk, tbl[i].ex, tbl[i].rd, tbl[i].tgt);

        // 16-bit alignment: 0x106 is a legal target
        cyc();
        v16 = 1'b1; req_funct3 = 3'b001; req_rs1 = 32'h1; req_rs2 = 32'h2;
        req_pc = 32'h100; req_imm = 32'h6;
        @(negedge clock);
        chk_b("a16_ready", req_ready16, 1'b1);
        cyc();
        v16 = 1'b0;
        @(negedge clock);
        cyc();
        @(negedge clock);
        chk_b("a16_redir_valid", redir_valid16, 1'b1);
        chk_w("a16_redir_pc", redir_pc16, 32'h106);
        chk_b("a16_no_done", done_valid16, 1'b0);
        cyc();
        rr16 = 1'b1;
        @(negedge clock);
        chk_b("a16_done", done_valid16, 1'b1);
        chk_b("a16_taken", done_taken16, 1'b1);
        chk_b("a16_exc", done_exc16, 1'b0);
        cyc();
        rr16 = 1'b0;
        @(negedge clock);
        chk_b("a16_idle", busy16, 1'b0);

        // flush during CMP kills the branch
        cyc();
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h5; req_rs2 = 32'h5;
        req_pc = 32'h100; req_imm = 32'h20;
        @(negedge clock);
        cyc();
        req_valid = 1'b0; flush_in = 1'b1;
        @(negedge clock);
        chk_b("fc_ready_low", req_ready, 1'b0);
        chk_b("fc_done", done_valid, 1'b0);
        cyc();
        flush_in = 1'b0;
        @(negedge clock);
        chk_b("fc_busy", busy, 1'b0);
        chk_b("fc_redir", redir_valid, 1'b0);
        chk_b("fc_done2", done_valid, 1'b0);
        cyc();
        @(negedge clock);
        chk_b("fc_redir2", redir_valid, 1'b0);

        // no acceptance while flushing
        cyc();
        req_valid = 1'b1; flush_in = 1'b1;
        @(negedge clock);
        chk_b("fi_ready", req_ready, 1'b0);
        cyc();
        req_valid = 1'b0; flush_in = 1'b0;
        @(negedge clock);
        chk_b("fi_busy", busy, 1'b0);

        // flush wins over a same-cycle redirect handshake
        to_redir();
        cyc();
        @(negedge clock);
        chk_b("fr_held", redir_valid, 1'b1);
        cyc();
        flush_in = 1'b1; redir_ready = 1'b1;
        @(negedge clock);
        chk_b("fr_no_done", done_valid, 1'b0);
        chk_b("fr_ready_low", req_ready, 1'b0);
        cyc();
        flush_in = 1'b0; redir_ready = 1'b0;
        @(negedge clock);
        chk_b("fr_redir_drop", redir_valid, 1'b0);
        chk_b("fr_busy", busy, 1'b0);
        chk_b("fr_done", done_valid, 1'b0);

        for (int k = 0; k < 150; k++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            pc = $urandom & 32'hFFFFFFFC;
            imm = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFFFFFC) : ($urandom & 32'hFFFFFFFE);
            model(f, a, b, pc, imm, tk, ex, rd, tgt);
            run_br(f, a, b, pc, imm, $urandom_range(0, 3), tk, ex, rd, tgt);
        end

`ifdef BRANCH_STATS_EN
        chk_w("stat_resolved", stat_resolved, n_res);
        chk_w("stat_taken", stat_taken, n_tk);
        chk_w("stat_exc", stat_exc, n_ex);
`endif

        // async reset between edges while redirecting
        to_redir();
        cyc();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk_b("ar_redir", redir_valid, 1'b0);
        chk_b("ar_busy", busy, 1'b0);
        chk_w("ar_pc", redir_pc, 32'h0);
        chk_b("ar_done", done_valid, 1'b0);
`ifdef BRANCH_STATS_EN
        chk_w("ar_stat_resolved", stat_resolved, 32'h0);
`endif
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_b("ar_ready", req_ready, 1'b1);
        run_br(3'b000, 32'h1, 32'h1, 32'h80, 32'h8, 0, 1'b1, 1'b0, 1'b1, 32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
